uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 34 +++
 rtl/baud_tick_gen.sv | 43 ++++
 rtl/uart_rx_cfg.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM state encoding and small helpers for the UART receiver.
package uart_pkg;

    // Parity modes accepted by the PARITY parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PAR    = 3'd3,
        ST_STOP   = 3'd4,
        ST_RESYNC = 3'd5
    } state_t;

    // Ceiling of log2; used to size counters from parameters.
    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        while ((longint'(1) << result) < longint'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Two-out-of-three vote used to decide each bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional accumulator producing BAUD*OVERSAMPLE ticks per second.
// Drift is bounded to one clock of jitter; there is no cumulative error.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    // One extra bit so acc + STEP (both below CLK_FREQ) never overflows.
    localparam int ACC_W = log2_ceil(CLK_FREQ) + 1;
    localparam logic [ACC_W-1:0] STEP = ACC_W'(BAUD * OVERSAMPLE);
    localparam logic [ACC_W-1:0] WRAP = ACC_W'(CLK_FREQ);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    assign sum = acc + STEP;

    // Accumulate the tick rate; emit a tick and subtract the clock rate on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (sum >= WRAP) begin
            acc  <= sum - WRAP;
            tick <= 1'b1;
        end else begin
            acc  <= sum;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable oversampling UART receiver with majority-vote bit
// decisions, parity/frame/break detection, valid/ready output and overrun flag.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 idle
);

    localparam int CNT_W     = log2_ceil(OVERSAMPLE);
    localparam int BIT_W     = log2_ceil(DATA_BITS);
    localparam int IDLE_CLKS = 2 * (DATA_BITS + 3) * (CLK_FREQ / BAUD);
    localparam int IDLE_W    = log2_ceil(IDLE_CLKS + 1);

    // Sample points sit around the middle of the bit.
    localparam logic [CNT_W-1:0]  SMP_FIRST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]  SMP_MID   = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0]  SMP_LAST  = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0]  CNT_END   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_END   = BIT_W'(DATA_BITS - 1);
    localparam logic [IDLE_W-1:0] IDLE_END  = IDLE_W'(IDLE_CLKS);

    logic [1:0]           sync_q;
    logic                 rxd_s;
    state_t               state;
    state_t               state_next;
    logic                 tick;
    logic [CNT_W-1:0]     tick_cnt;
    logic [1:0]           smp;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;
    logic [IDLE_W-1:0]    idle_cnt;

    logic bit_val;
    logic decide;
    logic bit_end;
    logic start_det;
    logic stop_done;
    logic par_fail;
    logic brk;

    assign rxd_s     = sync_q[1];
    assign bit_val   = maj3(smp[1], smp[0], rxd_s);
    assign decide    = tick && (tick_cnt == SMP_LAST);
    assign bit_end   = tick && (tick_cnt == CNT_END);
    assign start_det = (state == ST_IDLE) && !rxd_s;
    assign stop_done = (state == ST_STOP) && decide;

    // Expected parity is the data XOR, inverted in odd mode.
    assign par_fail = (PARITY != PAR_NONE) &&
                      (par_bit != ((^shift_reg) ^ (PARITY != PAR_EVEN)));
    assign brk      = (shift_reg == '0) && ((PARITY == PAR_NONE) || !par_bit) && !bit_val;

    baud_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state == ST_IDLE),
        .tick (tick)
    );

    // Two-flop synchroniser for the asynchronous line; resets to the idle level.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    // NOTE: state_next is given a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!rxd_s) state_next = ST_START;
            end
            ST_START: begin
                if (decide && bit_val) state_next = ST_IDLE;
                else if (bit_end)      state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt == BIT_END)) begin
                    state_next = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                end
            end
            ST_PAR: begin
                if (bit_end) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (decide) state_next = rxd_s ? ST_IDLE : ST_RESYNC;
            end
            ST_RESYNC: begin
                if (rxd_s && bit_end) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Tick counter, majority samples, data shifter, bit counter and parity capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            smp       <= 2'b00;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
        end else begin
            // RESYNC restarts its bit-time count whenever the line drops again.
            if ((state == ST_IDLE) || stop_done || ((state == ST_RESYNC) && !rxd_s)) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (tick && ((tick_cnt == SMP_FIRST) || (tick_cnt == SMP_MID))) begin
                smp <= {smp[0], rxd_s};
            end

            if (state != ST_DATA) begin
                bit_cnt <= '0;
            end else if (bit_end) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if ((state == ST_DATA) && decide) begin
                shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
            end

            if ((state == ST_PAR) && decide) begin
                par_bit <= bit_val;
            end
        end
    end

    // Output holding register with valid/ready handshake and overrun detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (stop_done) begin
                if (rx_valid && !rx_ready) begin
                    // Held word not yet consumed: drop the new one.
                    overrun <= 1'b1;
                end else begin
                    rx_valid   <= 1'b1;
                    rx_data    <= shift_reg;
                    frame_err  <= !bit_val;
                    parity_err <= par_fail;
                    break_det  <= brk;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Line-idle detector: counts clocks spent in IDLE, cleared by a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            idle     <= 1'b0;
        end else begin
            if (state != ST_IDLE) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_END) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (start_det) begin
                idle <= 1'b0;
            end else if ((state == ST_IDLE) && (idle_cnt == IDLE_END)) begin
                idle <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scenario and randomized checks of uart_rx_cfg against a
// frame-level reference model (8N1 instance and 7E1 instance, 16 clk per bit).
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bd;
    } rec_t;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       rxd_a      = 1'b1;
    logic       rxd_b      = 1'b1;
    logic       rx_ready_a = 1'b1;
    logic       rx_ready_b = 1'b1;
    logic [7:0] rx_data_a;
    logic [6:0] rx_data_b;
    logic       rx_valid_a, frame_err_a, parity_err_a, break_det_a, overrun_a, idle_a;
    logic       rx_valid_b, frame_err_b, parity_err_b, break_det_b, overrun_b, idle_b;

    int   checks   = 0;
    int   failures = 0;
    rec_t q_a[$];
    rec_t q_b[$];
    int   ovr_a    = 0;
    int   vcyc_a   = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .OVERSAMPLE(OS)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .rx_ready(rx_ready_a), .frame_err(frame_err_a), .parity_err(parity_err_a),
        .break_det(break_det_a), .overrun(overrun_a), .idle(idle_a)
    );

    uart_rx_cfg #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(1), .OVERSAMPLE(OS)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .rx_ready(rx_ready_b), .frame_err(frame_err_b), .parity_err(parity_err_b),
        .break_det(break_det_b), .overrun(overrun_b), .idle(idle_b)
    );

    // Monitors: record every accepted word, count overrun pulses and valid cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid_a && rx_ready_a)
                q_a.push_back(rec_t'({rx_data_a, parity_err_a, frame_err_a, break_det_a}));
            if (rx_valid_b && rx_ready_b)
                q_b.push_back(rec_t'({1'b0, rx_data_b, parity_err_b, frame_err_b, break_det_b}));
            if (overrun_a) ovr_a++;
            if (rx_valid_a) vcyc_a++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rxd_a = v;
        else          rxd_b = v;
    endtask

    // Parity bit a correct transmitter would send.
    function automatic logic par_of(input logic [7:0] d, input int nbits, input int pmode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ d[i];
        return (pmode == 2) ? ~p : p;
    endfunction

    // Reference model: what the receiver must report for a given transmitted frame.
    function automatic rec_t model(input logic [7:0] d, input int nbits, input int pmode,
                                   input bit flip, input bit stop_val);
        rec_t       r;
        logic [7:0] m;
        logic       sent_p;
        m      = d & 8'((1 << nbits) - 1);
        sent_p = par_of(d, nbits, pmode) ^ flip;
        r.data = m;
        r.pe   = (pmode != 0) && flip;
        r.fe   = !stop_val;
        r.bd   = (m == 8'h00) && ((pmode == 0) || !sent_p) && !stop_val;
        return r;
    endfunction

    // Serialise one frame (LSB first) followed by two idle bit times.
    task automatic send_frame(input int sel, input logic [7:0] d, input int nbits,
                              input int pmode, input bit flip, input bit stop_val);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) bits.push_back(d[i]);
        if (pmode != 0) bits.push_back(par_of(d, nbits, pmode) ^ flip);
        bits.push_back(stop_val);
        foreach (bits[i]) begin
            drive(sel, bits[i]);
            step(BIT_CLKS);
        end
        drive(sel, 1'b1);
        step(2 * BIT_CLKS);
    endtask

    task automatic pop(input int sel, output rec_t r, output bit ok);
        ok = 1'b0;
        r  = '0;
        if (sel == 0) begin
            if (q_a.size() > 0) begin r = q_a.pop_front(); ok = 1'b1; end
        end else begin
            if (q_b.size() > 0) begin r = q_b.pop_front(); ok = 1'b1; end
        end
    endtask

    task automatic test_reset();
        step(3);
        checks++;
        if ({rx_valid_a, rx_data_a, parity_err_a, frame_err_a, break_det_a, overrun_a, idle_a} !== 14'h0) begin
            failures++;
            $display("FAIL reset_outputs_a: got=%h expected=0",
                     {rx_valid_a, rx_data_a, parity_err_a, frame_err_a, break_det_a, overrun_a, idle_a});
        end
        checks++;
        if ({rx_valid_b, rx_data_b, parity_err_b, frame_err_b, break_det_b, overrun_b, idle_b} !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs_b: got=%h expected=0",
                     {rx_valid_b, rx_data_b, parity_err_b, frame_err_b, break_det_b, overrun_b, idle_b});
        end
        checks++;
        if (dut_a.state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state: got=%0d expected=%0d", dut_a.state, ST_IDLE);
        end
        rst_n = 1'b1;
    endtask

    // idle rises after 2*(8+3) bit times = 352 clk of quiet line.
    task automatic test_idle();
        step(300);
        checks++;
        if (idle_a !== 1'b0) begin
            failures++;
            $display("FAIL idle_early: got=%b expected=0", idle_a);
        end
        step(100);
        checks++;
        if (idle_a !== 1'b1) begin
            failures++;
            $display("FAIL idle_set: got=%b expected=1", idle_a);
        end
    endtask

    task automatic test_8n1();
        rec_t got, exp;
        bit   ok;
        int   v0;
        v0 = vcyc_a;
        send_frame(0, 8'hA5, 8, 0, 1'b0, 1'b1);
        pop(0, got, ok);
        exp = model(8'hA5, 8, 0, 1'b0, 1'b1);
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL 8n1_a5: got=%h present=%0d expected=%h", got, ok, exp);
        end
        checks++;
        if (vcyc_a - v0 !== 1) begin
            failures++;
            $display("FAIL 8n1_valid_width: got=%0d cycles expected=1", vcyc_a - v0);
        end
        checks++;
        if (idle_a !== 1'b0) begin
            failures++;
            $display("FAIL idle_cleared: got=%b expected=0", idle_a);
        end
    endtask

    task automatic test_7e1();
        rec_t got, exp;
        bit   ok;
        for (int f = 0; f < 2; f++) begin
            send_frame(1, 8'h35, 7, PAR_EVEN, f[0], 1'b1);
            pop(1, got, ok);
            exp = model(8'h35, 7, PAR_EVEN, f[0], 1'b1);
            checks++;
            if (!ok || got !== exp) begin
                failures++;
                $display("FAIL 7e1_35_flip%0d: got=%h present=%0d expected=%h", f, got, ok, exp);
            end
        end
    endtask

    task automatic test_false_start();
        rec_t got, exp;
        bit   ok;
        int   v0;
        v0 = vcyc_a;
        drive(0, 1'b0);
        step(4);
        drive(0, 1'b1);
        step(30);
        checks++;
        if (vcyc_a !== v0) begin
            failures++;
            $display("FAIL false_start_valid: got=%0d cycles expected=0", vcyc_a - v0);
        end
        checks++;
        if (dut_a.state !== ST_IDLE) begin
            failures++;
            $display("FAIL false_start_state: got=%0d expected=%0d", dut_a.state, ST_IDLE);
        end
        send_frame(0, 8'h3C, 8, 0, 1'b0, 1'b1);
        pop(0, got, ok);
        exp = model(8'h3C, 8, 0, 1'b0, 1'b1);
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL after_false_start: got=%h present=%0d expected=%h", got, ok, exp);
        end
    endtask

    task automatic test_overrun();
        rec_t got, exp;
        bit   ok;
        int   o0;
        o0 = ovr_a;
        rx_ready_a = 1'b0;
        send_frame(0, 8'h11, 8, 0, 1'b0, 1'b1);
        checks++;
        if ({rx_valid_a, rx_data_a} !== {1'b1, 8'h11}) begin
            failures++;
            $display("FAIL overrun_first_held: got=%h expected=%h", {rx_valid_a, rx_data_a}, {1'b1, 8'h11});
        end
        send_frame(0, 8'h22, 8, 0, 1'b0, 1'b1);
        checks++;
        if ({rx_valid_a, rx_data_a} !== {1'b1, 8'h11}) begin
            failures++;
            $display("FAIL overrun_data_kept: got=%h expected=%h", {rx_valid_a, rx_data_a}, {1'b1, 8'h11});
        end
        checks++;
        if (ovr_a - o0 !== 1) begin
            failures++;
            $display("FAIL overrun_pulses: got=%0d expected=1", ovr_a - o0);
        end
        rx_ready_a = 1'b1;
        step(1);
        checks++;
        if (rx_valid_a !== 1'b0) begin
            failures++;
            $display("FAIL overrun_accept_clear: got=%b expected=0", rx_valid_a);
        end
        pop(0, got, ok);
        exp = model(8'h11, 8, 0, 1'b0, 1'b1);
        checks++;
        if (!ok || got !== exp || q_a.size() != 0) begin
            failures++;
            $display("FAIL overrun_accepted_word: got=%h present=%0d left=%0d expected=%h", got, ok, q_a.size(), exp);
        end
    endtask

    task automatic test_break();
        rec_t got, exp;
        bit   ok;
        drive(0, 1'b0);
        step(20 * BIT_CLKS);
        checks++;
        if (dut_a.state !== ST_RESYNC) begin
            failures++;
            $display("FAIL break_resync: got=%0d expected=%0d", dut_a.state, ST_RESYNC);
        end
        pop(0, got, ok);
        exp = model(8'h00, 8, 0, 1'b0, 1'b0);
        checks++;
        if (!ok || got !== exp || q_a.size() != 0) begin
            failures++;
            $display("FAIL break_word: got=%h present=%0d left=%0d expected=%h", got, ok, q_a.size(), exp);
        end
        drive(0, 1'b1);
        step(8);
        checks++;
        if (dut_a.state !== ST_RESYNC) begin
            failures++;
            $display("FAIL break_resync_hold: got=%0d expected=%0d", dut_a.state, ST_RESYNC);
        end
        step(22);
        checks++;
        if (dut_a.state !== ST_IDLE) begin
            failures++;
            $display("FAIL break_back_idle: got=%0d expected=%0d", dut_a.state, ST_IDLE);
        end
        send_frame(0, 8'h5A, 8, 0, 1'b0, 1'b1);
        pop(0, got, ok);
        exp = model(8'h5A, 8, 0, 1'b0, 1'b1);
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL after_break_5a: got=%h present=%0d expected=%h", got, ok, exp);
        end
    endtask

    task automatic test_random();
        rec_t       got, exp;
        bit         ok, flip, stop_val;
        int         sel, nbits, pmode;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            sel      = int'($urandom_range(0, 1));
            d        = 8'($urandom);
            stop_val = ($urandom_range(0, 3) != 0);
            flip     = (sel == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            nbits    = (sel == 0) ? 8 : 7;
            pmode    = (sel == 0) ? PAR_NONE : PAR_EVEN;
            send_frame(sel, d, nbits, pmode, flip, stop_val);
            pop(sel, got, ok);
            exp = model(d, nbits, pmode, flip, stop_val);
            checks++;
            if (!ok || got !== exp) begin
                failures++;
                $display("FAIL random_%0d_sel%0d: got=%h present=%0d expected=%h", i, sel, got, ok, exp);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        rec_t       got, exp;
        bit         ok;
        logic [7:0] d;
        d = 8'hC3;
        rx_ready_a = 1'b0;
        send_frame(0, 8'h3C, 8, 0, 1'b0, 1'b1);
        checks++;
        if (rx_valid_a !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pending: got=%b expected=1", rx_valid_a);
        end
        drive(0, 1'b0);
        step(BIT_CLKS);
        for (int b = 0; b < 3; b++) begin
            drive(0, d[b]);
            step(BIT_CLKS);
        end
        drive(0, d[3]);
        step(BIT_CLKS / 2);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_valid_a, rx_data_a, parity_err_a, frame_err_a, break_det_a, overrun_a, idle_a} !== 14'h0) begin
            failures++;
            $display("FAIL midrst_outputs: got=%h expected=0",
                     {rx_valid_a, rx_data_a, parity_err_a, frame_err_a, break_det_a, overrun_a, idle_a});
        end
        drive(0, 1'b1);
        rx_ready_a = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(20);
        checks++;
        if (q_a.size() != 0) begin
            failures++;
            $display("FAIL midrst_no_output: got=%0d words expected=0", q_a.size());
        end
        send_frame(0, 8'h96, 8, 0, 1'b0, 1'b1);
        pop(0, got, ok);
        exp = model(8'h96, 8, 0, 1'b0, 1'b1);
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL midrst_next_frame: got=%h present=%0d expected=%h", got, ok, exp);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_8n1();
        test_7e1();
        test_false_start();
        test_overrun();
        test_break();
        test_random();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
